// File: rtl/ccff_chain_ctrl_pkg.sv
// Shared definitions for the configuration-chain controller: state encoding,
// per-tile chain geometry defaults and the word-chunking helper.
package ccff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } ccff_state_e;

    localparam int DEFAULT_CHAIN_LEN  = 20;
    localparam int DEFAULT_WORD_W     = 8;
    localparam int GRID_IO_CHAIN_LEN  = 4;
    localparam int GRID_IO_WORD_W     = 8;
    localparam int CLB_CHAIN_LEN      = 20;
    localparam int CLB_WORD_W         = 8;

    // Bits a word can still contribute without running past the chain end.
    function automatic int chunk_bits(input int remaining, input int word_w);
        return (remaining < word_w) ? remaining : word_w;
    endfunction

endpackage

// File: rtl/ccff_chain_ctrl_if.sv
// Host-side programming port: start pulses, load stream, readback stream, status.
interface ccff_chain_ctrl_if
    import ccff_ctrl_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
);
    logic              start_load;
    logic              start_read;
    logic [WORD_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [WORD_W-1:0] rdata;
    logic              rvalid;
    logic              rready;
    logic              busy;
    logic              done;

    modport master (
        output start_load, start_read, wdata, wvalid, rready,
        input  wready, rdata, rvalid, busy, done
    );

    modport slave (
        input  start_load, start_read, wdata, wvalid, rready,
        output wready, rdata, rvalid, busy, done
    );
endinterface

// File: rtl/ccff_chain_ctrl_shift_buf.sv
// Word buffer shared by load (parallel-in, serial-out LSB first) and readback
// (serial-in at an index, parallel-out). cnt counts remaining bits when
// draining and the next capture index when filling.
module ccff_shift_buf #(
    parameter  int WORD_W = 8,
    localparam int IDX_W  = $clog2(WORD_W + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_data_i,
    input  logic [IDX_W-1:0]  load_nbits_i,
    input  logic              shift_i,
    input  logic              cap_i,
    input  logic              cap_bit_i,
    output logic [WORD_W-1:0] data_o,
    output logic              ser_d_o,
    output logic [IDX_W-1:0]  cnt_o,
    output logic [IDX_W-1:0]  cnt_d_o,
    output logic              empty_o
);
    logic [WORD_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            data_d = load_data_i;
            cnt_d  = load_nbits_i;
        end else if (shift_i) begin
            data_d = {1'b0, data_q[WORD_W-1:1]};
            cnt_d  = cnt_q - IDX_W'(1);
        end else if (cap_i) begin
            for (int i = 0; i < WORD_W; i++) begin
                if (cnt_q == IDX_W'(i)) data_d[i] = cap_bit_i;
            end
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o  = data_q;
    assign ser_d_o = data_d[0];
    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/ccff_chain_ctrl.sv
// Configuration-chain controller: streams host words into the ccff chain one
// bit per prog_clk, and reads the chain back non-destructively by rotation.
module ccff_chain_ctrl
    import ccff_ctrl_pkg::*;
#(
    parameter  int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter  int WORD_W    = DEFAULT_WORD_W,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1),
    localparam int IDX_W     = $clog2(WORD_W + 1)
) (
    input  logic                prog_clk,
    input  logic                pReset,
    ccff_chain_ctrl_if.slave    host,
    output logic                ccff_head_o,
    input  logic                ccff_tail_i,
    output logic                ccff_clk_en_o
);
    ccff_state_e       state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              head_q, head_d;
    logic              en_q, en_d;

    logic              buf_clr, buf_load, buf_shift, buf_cap;
    logic [WORD_W-1:0] buf_data;
    logic              buf_ser_d;
    logic [IDX_W-1:0]  buf_idx, buf_cnt_d, nbits;
    logic              buf_empty;

    logic              last_bit, at_end, word_full, rd_shift;

    assign nbits     = IDX_W'(chunk_bits(CHAIN_LEN - int'(bit_cnt_q), WORD_W));
    assign last_bit  = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign at_end    = (bit_cnt_q == CNT_W'(CHAIN_LEN));
    assign word_full = (int'(buf_idx) == WORD_W - 1);
    assign rd_shift  = (state_q == READ) && !rvalid_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rvalid_d  = rvalid_q;
        buf_clr   = 1'b0;
        buf_load  = 1'b0;
        buf_shift = 1'b0;
        buf_cap   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host.start_load) begin
                    state_d   = LOAD;
                    bit_cnt_d = '0;
                    buf_clr   = 1'b1;
                end else if (host.start_read) begin
                    state_d   = READ;
                    bit_cnt_d = '0;
                    buf_clr   = 1'b1;
                end
            end
            LOAD: begin
                if (!buf_empty) begin
                    buf_shift = 1'b1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit) state_d = DONE;
                end else if (host.wvalid) begin
                    buf_load = 1'b1;
                end
            end
            READ: begin
                if (rvalid_q) begin
                    if (host.rready) begin
                        rvalid_d = 1'b0;
                        buf_clr  = 1'b1;
                        if (at_end) state_d = DONE;
                    end
                end else begin
                    // Final partial word closes early; its upper bits stay zero.
                    buf_cap   = 1'b1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (word_full || last_bit) rvalid_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load-side head/enable are registered from the buffer's next state so the
    // chain sees the bit on the edge after it was buffered.
    assign en_d   = (state_d == LOAD) && (buf_cnt_d != '0);
    assign head_d = en_d & buf_ser_d;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rvalid_q  <= 1'b0;
            head_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rvalid_q  <= rvalid_d;
            head_q    <= head_d;
            en_q      <= en_d;
        end
    end

    ccff_shift_buf #(.WORD_W(WORD_W)) u_buf (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .clr_i        (buf_clr),
        .load_i       (buf_load),
        .load_data_i  (host.wdata),
        .load_nbits_i (nbits),
        .shift_i      (buf_shift),
        .cap_i        (buf_cap),
        .cap_bit_i    (ccff_tail_i),
        .data_o       (buf_data),
        .ser_d_o      (buf_ser_d),
        .cnt_o        (buf_idx),
        .cnt_d_o      (buf_cnt_d),
        .empty_o      (buf_empty)
    );

    // Readback rotates the chain so its contents survive.
    assign ccff_head_o   = (state_q == READ) ? ccff_tail_i : head_q;
    assign ccff_clk_en_o = en_q | rd_shift;

    assign host.wready = (state_q == LOAD) && buf_empty;
    assign host.rvalid = rvalid_q;
    assign host.rdata  = rvalid_q ? buf_data : '0;
    assign host.busy   = (state_q != IDLE);
    assign host.done   = (state_q == DONE);
endmodule
